// File: rtl/audio_pkg.sv
// Shared audio types for the I2S receive path: the 16-bit sample type,
// the receiver FSM state encoding and the default slot length.
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        ALIGN = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        PAD   = 2'd3
    } rx_state_e;

    localparam int SLOT_BITS_DEFAULT = 32;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// N-stage synchronizer with rise/fall detection; the edge history only
// advances when en_i is high, so edges are measured between enabled samples.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    input  logic en_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            if (en_i) begin
                prev_q <= sync_q[STAGES-1];
            end
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = en_i & q_o & ~prev_q;
    assign fall_o = en_i & ~q_o & prev_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: captures the 16 MSBs of each channel slot and emits one sample
// per frame. Define I2S_RX_MONO_MIX_EN to output the averaged L/R mix instead of L.
module i2s_rx
    import audio_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SLOT_BITS   = SLOT_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bclk,
    input  logic        lrclk,
    input  logic        sdata,
    output logic [15:0] samp,
    output logic        samp_valid,
    output logic        frame_err
);

    logic bclkRise;
    logic lrRise;
    logic lrFall;
    logic lrEdge;
    logic sdataS;
    logic bclkLevel_unused;
    logic bclkFall_unused;
    logic lrLevel_unused;

    logic [SYNC_STAGES-1:0] sdataSync_q;

    rx_state_e state_q, state_d;
    sample_t   shift_q, shift_d;
    logic [3:0] bitCnt_q, bitCnt_d;
    logic [6:0] slotCnt_q, slotCnt_d;
    logic      chan_q, chan_d;
    sample_t   samp_q, samp_d;
    logic      valid_q, valid_d;
    logic      err_q, err_d;
    sample_t   word;
`ifdef I2S_RX_MONO_MIX_EN
    sample_t   left_q, left_d;
`endif

    sync_edge #(.STAGES(SYNC_STAGES)) uBclkSync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (bclk),
        .en_i   (1'b1),
        .q_o    (bclkLevel_unused),
        .rise_o (bclkRise),
        .fall_o (bclkFall_unused)
    );

    // lrclk edges are judged only between consecutive bclk-rise samples
    sync_edge #(.STAGES(SYNC_STAGES)) uLrSync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (lrclk),
        .en_i   (bclkRise),
        .q_o    (lrLevel_unused),
        .rise_o (lrRise),
        .fall_o (lrFall)
    );

    assign lrEdge = lrRise | lrFall;
    assign sdataS = sdataSync_q[SYNC_STAGES-1];
    assign word   = {shift_q[14:0], sdataS};

    always_ff @(posedge clk) begin
        if (!rst) begin
            sdataSync_q <= '0;
            state_q     <= ALIGN;
            shift_q     <= '0;
            bitCnt_q    <= '0;
            slotCnt_q   <= '0;
            chan_q      <= 1'b0;
            samp_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
`ifdef I2S_RX_MONO_MIX_EN
            left_q      <= '0;
`endif
        end else begin
            sdataSync_q <= {sdataSync_q[SYNC_STAGES-2:0], sdata};
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitCnt_q    <= bitCnt_d;
            slotCnt_q   <= slotCnt_d;
            chan_q      <= chan_d;
            samp_q      <= samp_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
`ifdef I2S_RX_MONO_MIX_EN
            left_q      <= left_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bitCnt_d  = bitCnt_q;
        slotCnt_d = slotCnt_q;
        chan_d    = chan_q;
        samp_d    = samp_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
`ifdef I2S_RX_MONO_MIX_EN
        left_d    = left_q;
`endif
        if (bclkRise) begin
            // The rise carrying an lrclk edge is the first rise of the new slot
            if (state_q != ALIGN) begin
                slotCnt_d = lrEdge ? 7'd1 : slotCnt_q + 7'd1;
            end
            case (state_q)
                ALIGN: begin
                    if (lrFall) begin
                        state_d   = DELAY;
                        chan_d    = 1'b0;
                        slotCnt_d = 7'd1;
                    end
                end
                DELAY: begin
                    if (lrEdge) begin
                        state_d = ALIGN;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = SHIFT;
                        bitCnt_d = 4'd0;
                        shift_d  = '0;
                    end
                end
                SHIFT: begin
                    if (lrEdge) begin
                        state_d = ALIGN;
                        err_d   = 1'b1;
                        shift_d = '0;
                    end else begin
                        shift_d  = word;
                        bitCnt_d = bitCnt_q + 4'd1;
                        if (bitCnt_q == 4'd15) begin
                            state_d = PAD;
`ifdef I2S_RX_MONO_MIX_EN
                            if (!chan_q) begin
                                left_d = word;
                            end else begin
                                samp_d  = (left_q >>> 1) + (word >>> 1);
                                valid_d = 1'b1;
                            end
`else
                            if (!chan_q) begin
                                samp_d  = word;
                                valid_d = 1'b1;
                            end
`endif
                        end
                    end
                end
                PAD: begin
                    if (lrEdge) begin
                        state_d = DELAY;
                        chan_d  = lrRise;
                    end
                end
            endcase
            // A slot that outlives SLOT_BITS rises means the framing is lost
            if (state_q != ALIGN && !lrEdge && slotCnt_q == 7'(SLOT_BITS)) begin
                state_d = ALIGN;
                err_d   = 1'b1;
                valid_d = 1'b0;
                samp_d  = samp_q;
                shift_d = '0;
`ifdef I2S_RX_MONO_MIX_EN
                left_d  = left_q;
`endif
            end
        end
    end

    assign samp       = samp_q;
    assign samp_valid = valid_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: random and directed I2S frames against a
// frame-level reference model; honours I2S_RX_MONO_MIX_EN when defined.
`timescale 1ns/1ps
module tb_i2s_rx;

    localparam int SYNC      = 2;
    localparam int SLOT      = 32;
    localparam int BCLK_HALF = 160;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        bclk  = 1'b0;
    logic        lrclk = 1'b1;
    logic        sdata = 1'b0;
    logic [15:0] samp;
    logic        samp_valid;
    logic        frame_err;

    int checks     = 0;
    int errors     = 0;
    int cycleCnt   = 0;
    int riseCycle  = 0;
    int errCnt     = 0;
    int errBase    = 0;
    int dblCnt     = 0;
    int overlapCnt = 0;
    bit prevValid  = 1'b0;
    logic [15:0] obsQ[$];
    int          latQ[$];

    always #10 clk = ~clk;

    i2s_rx #(.SYNC_STAGES(SYNC), .SLOT_BITS(SLOT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .samp       (samp),
        .samp_valid (samp_valid),
        .frame_err  (frame_err)
    );

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Output monitor: collects samples, strobe latency and strobe-rule breaches
    always @(negedge clk) begin
        if (samp_valid === 1'b1) begin
            obsQ.push_back(samp);
            latQ.push_back(cycleCnt - riseCycle);
            if (prevValid) dblCnt++;
            if (frame_err === 1'b1) overlapCnt++;
        end
        if (frame_err === 1'b1) errCnt++;
        prevValid = (samp_valid === 1'b1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: left word, or floor(L/2)+floor(R/2) when mixing to mono
    function automatic logic [15:0] expSamp(input logic [15:0] l, input logic [15:0] r);
        int sl;
        int sr;
        logic [15:0] mix;
        sl  = int'($signed(l));
        sr  = int'($signed(r));
        mix = 16'(((sl - (sl & 1)) / 2) + ((sr - (sr & 1)) / 2));
`ifdef I2S_RX_MONO_MIX_EN
        return mix;
`else
        if (mix == 16'hFFFF && sl == -1 && sr == -1) return l;
        return l;
`endif
    endfunction

    task automatic sendBit(input logic lr, input logic d, input bit mark);
        bclk  = 1'b0;
        lrclk = lr;
        sdata = d;
        #(BCLK_HALF);
        bclk = 1'b1;
        if (mark) riseCycle = cycleCnt;
        #(BCLK_HALF);
    endtask

    // Slot layout: rise 0 carries the lrclk edge, rise 1 is the one-bit
    // delay, rises 2..17 carry the word MSB first, the rest is filler.
    task automatic sendSlot(input logic lr, input logic [15:0] word, input int nBits);
        logic       b;
        logic [3:0] idx;
        for (int j = 0; j < nBits; j++) begin
            if (j >= 2 && j < 18) begin
                idx = 4'(17 - j);
                b   = word[idx];
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            sendBit(lr, b, j == 17);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input int rightBits);
        sendSlot(1'b0, l, SLOT);
        sendSlot(1'b1, r, rightBits);
    endtask

    task automatic checkFrame(input string tag, input int expN, input logic [15:0] expVal, input int expErr);
        repeat (12) @(negedge clk);
        checkOutput({tag, ":count"}, obsQ.size(), expN);
        if (expN == 1 && obsQ.size() == 1) begin
            checkOutput({tag, ":samp"}, {16'h0, obsQ[0]}, {16'h0, expVal});
            checkOutput({tag, ":latency"}, latQ[0], SYNC + 1);
        end
        checkOutput({tag, ":frameErr"}, errCnt - errBase, expErr);
        obsQ.delete();
        latQ.delete();
        errBase = errCnt;
    endtask

    initial begin
        logic [15:0] l;
        logic [15:0] r;

        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("reset:samp", {16'h0, samp}, 32'h0);
        checkOutput("reset:valid", {31'h0, samp_valid}, 32'h0);
        checkOutput("reset:frameErr", {31'h0, frame_err}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Stream joins in the middle of a right slot
        sendSlot(1'b1, 16'h0, 20);
        checkFrame("midRight", 0, 16'h0, 0);

        applyStimulus(16'h1234, 16'hABCD, SLOT);
        checkFrame("frame1234", 1, expSamp(16'h1234, 16'hABCD), 0);
        applyStimulus(16'h4000, 16'hC000, SLOT);
        checkFrame("frame4000", 1, expSamp(16'h4000, 16'hC000), 0);
        applyStimulus(16'h7FFE, 16'h7FFE, SLOT);
        checkFrame("frame7FFE", 1, expSamp(16'h7FFE, 16'h7FFE), 0);

        for (int i = 0; i < 6; i++) begin
            l = 16'($urandom);
            r = 16'($urandom);
            applyStimulus(l, r, SLOT);
            checkFrame("random", 1, expSamp(l, r), 0);
        end

        // Left slot cut short after 10 data bits
        l = 16'($urandom);
        r = 16'($urandom);
        sendSlot(1'b0, l, 12);
        sendSlot(1'b1, r, SLOT);
        checkFrame("shortSlot", 0, 16'h0, 1);
        l = 16'($urandom);
        r = 16'($urandom);
        applyStimulus(l, r, SLOT);
        checkFrame("afterShort", 1, expSamp(l, r), 0);

        // Reset pulse in the middle of the left-slot shift
        sendSlot(1'b0, 16'($urandom), 10);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midReset:samp", {16'h0, samp}, 32'h0);
        checkOutput("midReset:valid", {31'h0, samp_valid}, 32'h0);
        checkOutput("midReset:frameErr", {31'h0, frame_err}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        sendSlot(1'b0, 16'($urandom), 22);
        sendSlot(1'b1, 16'($urandom), SLOT);
        checkFrame("afterReset", 0, 16'h0, 0);
        l = 16'($urandom);
        r = 16'($urandom);
        applyStimulus(l, r, SLOT);
        checkFrame("resume", 1, expSamp(l, r), 0);

        // Right slot runs 40 rises without an lrclk edge
        l = 16'($urandom);
        r = 16'($urandom);
        applyStimulus(l, r, 40);
        checkFrame("overflow", 1, expSamp(l, r), 1);
        l = 16'($urandom);
        r = 16'($urandom);
        applyStimulus(l, r, SLOT);
        checkFrame("realign", 1, expSamp(l, r), 0);

        checkOutput("validTwice", dblCnt, 0);
        checkOutput("validWithErr", overlapCnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
